fmul_round_pack: RTL and testbench

Parametrised final stage of the floating-point multiplier. It takes the normalised product (sign, extended exponent, mantissa with guard/sticky) plus operand class codes. It applies round-to-nearest-even, resolves IEEE-754 special cases and sets exception flags. Results are buffered in an output FIFO, so upstream busy is a registered signal with no combinational path from downstream busy. Format-generic: covers binary16/32/64 by parameter.

---
 rtl/fmul_pkg.sv | 32 +++
 rtl/fmul_round_pack_if.sv | 31 +++
 rtl/fmul_out_fifo.sv | 55 +++++
 rtl/fmul_round_pack.sv | 141 ++++++++++++++
 tb/tb_fmul_round_pack.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/fmul_pkg.sv
// Shared types and special-value encodings for the floating-point multiplier
// round/pack stage.
package fmul_pkg;

    typedef enum logic [2:0] {
        FINITE = 3'b000,
        ZERO   = 3'b001,
        INF    = 3'b010,
        QNAN   = 3'b011,
        SNAN   = 3'b100
    } fmul_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fmul_flags_t;

    // Encoding of qNaN/inf/zero, right-aligned in 64 bits; callers size-cast to their format.
    function automatic logic [63:0] special_enc(input int exp_w, input int fract_w,
                                                input fmul_class_e kind, input logic sign);
        logic [63:0] enc;
        enc = 64'(sign) << (exp_w + fract_w);
        if (kind != ZERO)
            enc = enc | (((64'd1 << exp_w) - 64'd1) << fract_w);
        if (kind == QNAN)
            enc = enc | (64'd1 << (fract_w - 1));
        return enc;
    endfunction

endpackage

// File: rtl/fmul_round_pack_if.sv
// Upstream product bus and downstream result bus of the round/pack stage.
interface fmul_round_pack_if #(
    parameter int P_EXP_W   = 8,
    parameter int P_FRACT_W = 23
) ();

    logic                         iDATA_VALID;
    logic                         oDATA_BUSY;
    logic                         iDATA_SIGN;
    logic [P_EXP_W+1:0]           iDATA_EXP;
    logic [P_FRACT_W+2:0]         iDATA_MANT;
    logic [2:0]                   iDATA_CLASS_A;
    logic [2:0]                   iDATA_CLASS_B;
    logic                         oDATA_VALID;
    logic                         iDATA_BUSY;
    logic [P_EXP_W+P_FRACT_W:0]   oDATA;
    logic [3:0]                   oFLAGS;

    modport slave (
        input  iDATA_VALID, iDATA_SIGN, iDATA_EXP, iDATA_MANT,
        input  iDATA_CLASS_A, iDATA_CLASS_B, iDATA_BUSY,
        output oDATA_BUSY, oDATA_VALID, oDATA, oFLAGS
    );

    modport master (
        output iDATA_VALID, iDATA_SIGN, iDATA_EXP, iDATA_MANT,
        output iDATA_CLASS_A, iDATA_CLASS_B, iDATA_BUSY,
        input  oDATA_BUSY, oDATA_VALID, oDATA, oFLAGS
    );

endinterface

// File: rtl/fmul_out_fifo.sv
// In-order result buffer with synchronous push/pop, any depth >= 2, and
// both asynchronous and synchronous clear.
module fmul_out_fifo #(
    parameter int P_WIDTH = 8,
    parameter int P_DEPTH = 2
) (
    input  logic                           iCLOCK,
    input  logic                           inRESET,
    input  logic                           iRESET_SYNC,
    input  logic                           push,
    input  logic [P_WIDTH-1:0]             push_data,
    input  logic                           pop,
    output logic [P_WIDTH-1:0]             head_data,
    output logic [$clog2(P_DEPTH+1)-1:0]   count
);

    localparam int PTR_W = (P_DEPTH > 1) ? $clog2(P_DEPTH) : 1;

    logic [P_WIDTH-1:0] mem [P_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(P_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < P_DEPTH; i++) mem[i] <= '0;
        end else if (iRESET_SYNC) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < P_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop)
                rd_ptr <= ptr_next(rd_ptr);
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fmul_round_pack.sv
// Final multiplier stage: round-to-nearest-even, special-case resolution,
// exception flags, and an output FIFO with registered upstream busy.
module fmul_round_pack
    import fmul_pkg::*;
#(
    parameter int P_EXP_W      = 8,
    parameter int P_FRACT_W    = 23,
    parameter int P_FIFO_DEPTH = 2
) (
    input  logic           iCLOCK,
    input  logic           inRESET,
    input  logic           iRESET_SYNC,
    fmul_round_pack_if.slave bus
);

    localparam int DATA_W = 1 + P_EXP_W + P_FRACT_W;
    localparam int EXT_W  = P_EXP_W + 3;
    localparam int CNT_W  = $clog2(P_FIFO_DEPTH + 1);
    localparam int OCC_W  = CNT_W + 2;
    localparam logic signed [EXT_W-1:0] EXP_MAX = EXT_W'((1 << P_EXP_W) - 1);

    logic                   accept;
    logic                   in_valid, in_sign;
    logic [P_EXP_W+1:0]     in_exp;
    logic [P_FRACT_W+2:0]   in_mant;
    logic [2:0]             in_class_a, in_class_b;

    logic                   r_valid;
    logic [DATA_W-1:0]      r_data, res_data;
    fmul_flags_t            r_flags, res_flags;

    logic [DATA_W+3:0]      head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_pop;
    logic [OCC_W-1:0]       occ;

    // Every accepted beat still in flight is counted, so the FIFO always has room when it lands.
    assign occ          = OCC_W'(fifo_count) + OCC_W'(in_valid) + OCC_W'(r_valid);
    assign bus.oDATA_BUSY = (occ >= OCC_W'(P_FIFO_DEPTH));
    assign accept       = bus.iDATA_VALID && !bus.oDATA_BUSY;

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            in_valid <= 1'b0;
            in_sign <= 1'b0; in_exp <= '0; in_mant <= '0; in_class_a <= '0; in_class_b <= '0;
        end else if (iRESET_SYNC) begin
            in_valid <= 1'b0;
            in_sign <= 1'b0; in_exp <= '0; in_mant <= '0; in_class_a <= '0; in_class_b <= '0;
        end else begin
            in_valid <= accept;
            if (accept) begin
                in_sign    <= bus.iDATA_SIGN;
                in_exp     <= bus.iDATA_EXP;
                in_mant    <= bus.iDATA_MANT;
                in_class_a <= bus.iDATA_CLASS_A;
                in_class_b <= bus.iDATA_CLASS_B;
            end
        end
    end

    logic [P_FRACT_W:0]     sig;
    logic                   inc;
    logic [P_FRACT_W+1:0]   m;
    logic signed [EXT_W-1:0] e_rnd;
    logic                   any_snan, any_qnan, any_inf, any_zero;

    always_comb begin
        sig   = in_mant[P_FRACT_W+2:2];
        inc   = in_mant[1] & (in_mant[0] | sig[0]);
        m     = {1'b0, sig} + {{(P_FRACT_W+1){1'b0}}, inc};
        e_rnd = $signed({in_exp[P_EXP_W+1], in_exp}) + $signed({{(EXT_W-1){1'b0}}, m[P_FRACT_W+1]});

        any_snan = (in_class_a == SNAN) || (in_class_b == SNAN);
        any_qnan = (in_class_a == QNAN) || (in_class_b == QNAN);
        any_inf  = (in_class_a == INF)  || (in_class_b == INF);
        any_zero = (in_class_a == ZERO) || (in_class_b == ZERO);

        res_flags = '0;
        res_data  = {in_sign, e_rnd[P_EXP_W-1:0], (m[P_FRACT_W+1] ? {P_FRACT_W{1'b0}} : m[P_FRACT_W-1:0])};

        if (any_snan) begin
            res_data          = DATA_W'(special_enc(P_EXP_W, P_FRACT_W, QNAN, in_sign));
            res_flags.invalid = 1'b1;
        end else if (any_qnan) begin
            res_data = DATA_W'(special_enc(P_EXP_W, P_FRACT_W, QNAN, in_sign));
        end else if (any_inf && any_zero) begin
            res_data          = DATA_W'(special_enc(P_EXP_W, P_FRACT_W, QNAN, in_sign));
            res_flags.invalid = 1'b1;
        end else if (any_inf) begin
            res_data = DATA_W'(special_enc(P_EXP_W, P_FRACT_W, INF, in_sign));
        end else if (any_zero) begin
            res_data = DATA_W'(special_enc(P_EXP_W, P_FRACT_W, ZERO, in_sign));
        end else begin
            res_flags.inexact = in_mant[1] | in_mant[0];
            if (!e_rnd[EXT_W-1] && (e_rnd >= EXP_MAX)) begin
                res_data           = DATA_W'(special_enc(P_EXP_W, P_FRACT_W, INF, in_sign));
                res_flags.overflow = 1'b1;
                res_flags.inexact  = 1'b1;
            end else if (e_rnd[EXT_W-1] || (e_rnd == '0)) begin
                res_data            = DATA_W'(special_enc(P_EXP_W, P_FRACT_W, ZERO, in_sign));
                res_flags.underflow = 1'b1;
                res_flags.inexact   = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLOCK or negedge inRESET) begin
        if (!inRESET) begin
            r_valid <= 1'b0; r_data <= '0; r_flags <= '0;
        end else if (iRESET_SYNC) begin
            r_valid <= 1'b0; r_data <= '0; r_flags <= '0;
        end else begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data  <= res_data;
                r_flags <= res_flags;
            end
        end
    end

    assign bus.oDATA_VALID = (fifo_count != '0);
    assign fifo_pop        = bus.oDATA_VALID && !bus.iDATA_BUSY;

    fmul_out_fifo #(
        .P_WIDTH (DATA_W + 4),
        .P_DEPTH (P_FIFO_DEPTH)
    ) u_fifo (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .push        (r_valid),
        .push_data   ({r_flags, r_data}),
        .pop         (fifo_pop),
        .head_data   (head),
        .count       (fifo_count)
    );

    assign bus.oDATA  = head[DATA_W-1:0];
    assign bus.oFLAGS = head[DATA_W+3:DATA_W];

endmodule

// File: tb/tb_fmul_round_pack.sv
// Scoreboard bench for fmul_round_pack in binary32 with a 2-entry output FIFO.
module tb_fmul_round_pack;
    import fmul_pkg::*;

    logic iCLOCK = 1'b0;
    logic inRESET = 1'b0;
    logic iRESET_SYNC = 1'b0;

    int n_cmp = 0;
    int n_fail = 0;
    logic [35:0] exp_q [$];

    fmul_round_pack_if #(.P_EXP_W(8), .P_FRACT_W(23)) bus ();

    fmul_round_pack #(
        .P_EXP_W      (8),
        .P_FRACT_W    (23),
        .P_FIFO_DEPTH (2)
    ) dut (
        .iCLOCK      (iCLOCK),
        .inRESET     (inRESET),
        .iRESET_SYNC (iRESET_SYNC),
        .bus         (bus)
    );

    always #5 iCLOCK = ~iCLOCK;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Presents a beat, waits (bounded) for acceptance, and queues its expected result; leaves valid high.
    task automatic applyStimulus(input logic s, input logic [9:0] e, input logic [25:0] m,
                                 input logic [2:0] ca, input logic [2:0] cb,
                                 input logic [31:0] xd, input logic [3:0] xf);
        int waited = 0;
        bus.iDATA_VALID   = 1'b1;
        bus.iDATA_SIGN    = s;
        bus.iDATA_EXP     = e;
        bus.iDATA_MANT    = m;
        bus.iDATA_CLASS_A = ca;
        bus.iDATA_CLASS_B = cb;
        @(negedge iCLOCK);
        while (bus.oDATA_BUSY && waited < 50) begin
            @(negedge iCLOCK);
            waited++;
        end
        if (bus.oDATA_BUSY) begin
            n_cmp++;
            n_fail++;
            $display("[TB] FAIL accept_timeout: busy still %b after %0d cycles, expected 0", bus.oDATA_BUSY, waited);
            bus.iDATA_VALID = 1'b0;
        end else begin
            exp_q.push_back({xf, xd});
        end
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic idle();
        bus.iDATA_VALID = 1'b0;
    endtask

    // Monitor: every real pop is compared against the oldest queued expectation.
    initial begin
        logic [35:0] want;
        forever begin
            @(negedge iCLOCK);
            if (inRESET && !iRESET_SYNC && bus.oDATA_VALID && !bus.iDATA_BUSY) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("[TB] FAIL unexpected_output: got %h, expected no beat", {bus.oFLAGS, bus.oDATA});
                end else begin
                    want = exp_q.pop_front();
                    if ({bus.oFLAGS, bus.oDATA} !== want) begin
                        n_fail++;
                        $display("[TB] FAIL result: got flags %b data %h, expected flags %b data %h",
                                 bus.oFLAGS, bus.oDATA, want[35:32], want[31:0]);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bus.iDATA_VALID = 1'b0; bus.iDATA_SIGN = 1'b0; bus.iDATA_EXP = '0; bus.iDATA_MANT = '0;
        bus.iDATA_CLASS_A = FINITE; bus.iDATA_CLASS_B = FINITE; bus.iDATA_BUSY = 1'b0;

        repeat (3) @(negedge iCLOCK);
        checkOutput("rst_valid", 64'(bus.oDATA_VALID), 64'd0);
        checkOutput("rst_busy",  64'(bus.oDATA_BUSY),  64'd0);
        checkOutput("rst_data",  64'(bus.oDATA),       64'd0);
        checkOutput("rst_flags", 64'(bus.oFLAGS),      64'd0);
        @(posedge iCLOCK); #1;
        inRESET = 1'b1;
        @(posedge iCLOCK); #1;

        // 1.5 in binary32, with a latency check
        applyStimulus(1'b0, 10'd127, {1'b1, 23'h400000, 2'b00}, FINITE, FINITE, 32'h3FC00000, 4'b0000);
        idle();
        @(negedge iCLOCK); checkOutput("lat_edge0", 64'(bus.oDATA_VALID), 64'd0);
        @(negedge iCLOCK); checkOutput("lat_edge1", 64'(bus.oDATA_VALID), 64'd0);
        @(negedge iCLOCK); checkOutput("lat_edge2", 64'(bus.oDATA_VALID), 64'd1);
        @(posedge iCLOCK); #1;

        // Rounding, range limits and specials
        applyStimulus(1'b0, 10'd127, {1'b1, 23'h000001, 2'b10}, FINITE, FINITE, 32'h3F800002, 4'b0001);
        applyStimulus(1'b0, 10'd127, {1'b1, 23'h000002, 2'b10}, FINITE, FINITE, 32'h3F800002, 4'b0001);
        applyStimulus(1'b0, 10'd127, {1'b1, 23'h7FFFFF, 2'b10}, FINITE, FINITE, 32'h40000000, 4'b0001);
        applyStimulus(1'b0, 10'd254, {1'b1, 23'h7FFFFF, 2'b11}, FINITE, FINITE, 32'h7F800000, 4'b0101);
        applyStimulus(1'b0, 10'd254, {1'b1, 23'h000000, 2'b01}, FINITE, FINITE, 32'h7F000000, 4'b0001);
        applyStimulus(1'b0, 10'd0,   {1'b1, 23'h000000, 2'b00}, FINITE, FINITE, 32'h00000000, 4'b0011);
        applyStimulus(1'b1, 10'h3FB, {1'b1, 23'h123456, 2'b00}, FINITE, FINITE, 32'h80000000, 4'b0011);
        applyStimulus(1'b1, 10'd128, {1'b1, 23'h000000, 2'b00}, FINITE, FINITE, 32'hC0000000, 4'b0000);
        applyStimulus(1'b1, 10'd5,   {1'b1, 23'h000000, 2'b00}, INF,    ZERO,   32'hFFC00000, 4'b1000);
        applyStimulus(1'b0, 10'd5,   {1'b1, 23'h000000, 2'b00}, SNAN,   FINITE, 32'h7FC00000, 4'b1000);
        applyStimulus(1'b0, 10'd5,   {1'b1, 23'h000000, 2'b00}, QNAN,   ZERO,   32'h7FC00000, 4'b0000);
        applyStimulus(1'b1, 10'd5,   {1'b1, 23'h000000, 2'b00}, INF,    FINITE, 32'hFF800000, 4'b0000);
        applyStimulus(1'b1, 10'd5,   {1'b1, 23'h000000, 2'b00}, FINITE, ZERO,   32'h80000000, 4'b0000);
        idle();
        repeat (6) @(posedge iCLOCK); #1;

        // Backpressure: stall downstream, four back-to-back beats
        bus.iDATA_BUSY = 1'b1;
        applyStimulus(1'b0, 10'd127, {1'b1, 23'h000010, 2'b00}, FINITE, FINITE, 32'h3F800010, 4'b0000);
        applyStimulus(1'b0, 10'd127, {1'b1, 23'h000020, 2'b00}, FINITE, FINITE, 32'h3F800020, 4'b0000);
        fork
            begin
                applyStimulus(1'b0, 10'd127, {1'b1, 23'h000030, 2'b00}, FINITE, FINITE, 32'h3F800030, 4'b0000);
                applyStimulus(1'b0, 10'd127, {1'b1, 23'h000040, 2'b00}, FINITE, FINITE, 32'h3F800040, 4'b0000);
                idle();
            end
            begin
                @(negedge iCLOCK); checkOutput("bp_busy_after2", 64'(bus.oDATA_BUSY), 64'd1);
                repeat (4) @(negedge iCLOCK);
                checkOutput("bp_busy_held", 64'(bus.oDATA_BUSY), 64'd1);
                checkOutput("bp_head_stable", 64'(bus.oDATA), 64'h3F800010);
                @(posedge iCLOCK); #1;
                bus.iDATA_BUSY = 1'b0;
            end
        join
        repeat (10) @(posedge iCLOCK); #1;
        checkOutput("bp_queue_drained", 64'(exp_q.size()), 64'd0);

        // Synchronous clear with two beats buffered
        bus.iDATA_BUSY = 1'b1;
        applyStimulus(1'b0, 10'd127, {1'b1, 23'h000050, 2'b00}, FINITE, FINITE, 32'h3F800050, 4'b0000);
        applyStimulus(1'b0, 10'd127, {1'b1, 23'h000060, 2'b00}, FINITE, FINITE, 32'h3F800060, 4'b0000);
        idle();
        repeat (3) @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b1;
        exp_q.delete();
        @(posedge iCLOCK); #1;
        iRESET_SYNC = 1'b0;
        @(negedge iCLOCK);
        checkOutput("sync_valid", 64'(bus.oDATA_VALID), 64'd0);
        checkOutput("sync_busy",  64'(bus.oDATA_BUSY),  64'd0);
        checkOutput("sync_data",  64'(bus.oDATA),       64'd0);
        bus.iDATA_BUSY = 1'b0;
        @(posedge iCLOCK); #1;
        applyStimulus(1'b1, 10'd130, {1'b1, 23'h200000, 2'b00}, FINITE, FINITE, 32'hC1200000, 4'b0000);
        idle();
        @(negedge iCLOCK); checkOutput("sync_lat_edge0", 64'(bus.oDATA_VALID), 64'd0);
        @(negedge iCLOCK); checkOutput("sync_lat_edge1", 64'(bus.oDATA_VALID), 64'd0);
        @(negedge iCLOCK); checkOutput("sync_lat_edge2", 64'(bus.oDATA_VALID), 64'd1);

        repeat (5) @(posedge iCLOCK); #1;
        checkOutput("final_queue_empty", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
